// File: rtl/batch_out_fixed.sv
// Float-to-fixed output stage: drops the start-up transient, converts samples to
// saturated signed fixed point and streams them out of a small FWFT FIFO.
module batch_out_fixed #(
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 23,
    parameter int OUT_W      = 16,
    parameter int FRAC_W     = 15,
    parameter int FIFO_DEPTH = 8,
    parameter int DISCARD    = 660
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [EXP_W+MANT_W:0]       in_data,
    input  logic                        in_valid,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        sat_flag,
    output logic                        ovf_flag,
    input  logic                        clr_flags
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CNT_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int MAG_W = MANT_W + OUT_W + 2;

    localparam logic [CNT_W-1:0] DISC_C  = CNT_W'(DISCARD);
    localparam logic [MAG_W-1:0] NEG_MAG = MAG_W'(1) << (OUT_W - 1);
    localparam logic [MAG_W-1:0] POS_MAX = NEG_MAG - MAG_W'(1);
    localparam logic [OUT_W-1:0] POS_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    // Start-up discard
    logic [CNT_W-1:0] disc_cnt;
    logic             accept;

    assign accept = in_valid && (disc_cnt == DISC_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disc_cnt <= '0;
        end else if (in_valid && (disc_cnt != DISC_C)) begin
            disc_cnt <= disc_cnt + CNT_W'(1);
        end
    end

    // Stage 1: field split and classification
    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W:0]   s1_mant;
    logic              s1_zero;
    logic              s1_special;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_mant    <= '0;
            s1_zero    <= 1'b0;
            s1_special <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign    <= in_data[EXP_W+MANT_W];
                s1_exp     <= in_data[EXP_W+MANT_W-1:MANT_W];
                s1_mant    <= {1'b1, in_data[MANT_W-1:0]};
                s1_zero    <= (in_data[EXP_W+MANT_W-1:MANT_W] == '0);
                s1_special <= (in_data[EXP_W+MANT_W-1:MANT_W] == '1);
            end
        end
    end

    // Stage 2 combinational conversion
    int               shift_s;
    int               rsh;
    logic [MAG_W-1:0] mant_w;
    logic [MAG_W-1:0] mag;
    logic             rnd_bit;
    logic             huge;
    logic [OUT_W-1:0] conv;
    logic             conv_sat;

    always_comb begin
        mant_w  = MAG_W'(s1_mant);
        shift_s = int'(s1_exp) - BIAS + FRAC_W - MANT_W;
        rsh     = 0;
        rnd_bit = 1'b0;
        huge    = 1'b0;
        mag     = '0;
        if (shift_s >= 0) begin
            // anything shifted past OUT_W is far beyond full scale
            if (shift_s > OUT_W) begin
                huge = 1'b1;
            end else begin
                mag = mant_w << shift_s;
            end
        end else begin
            rsh     = -shift_s;
            rnd_bit = ((mant_w >> (rsh - 1)) & MAG_W'(1)) != '0;
            mag     = (mant_w >> rsh) + MAG_W'(rnd_bit);
        end

        conv     = '0;
        conv_sat = 1'b0;
        if (s1_zero) begin
            conv = '0;
        end else if (s1_special) begin
            conv     = s1_sign ? NEG_OUT : POS_OUT;
            conv_sat = 1'b1;
        end else if (s1_sign) begin
            if (huge || (mag > NEG_MAG)) begin
                conv     = NEG_OUT;
                conv_sat = 1'b1;
            end else begin
                conv = -mag[OUT_W-1:0];
            end
        end else begin
            if (huge || (mag > POS_MAX)) begin
                conv     = POS_OUT;
                conv_sat = 1'b1;
            end else begin
                conv = mag[OUT_W-1:0];
            end
        end
    end

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= conv;
            end
        end
    end

    // Output FIFO
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_nxt;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_nxt;
    logic             full;
    logic             do_pop;
    logic             do_write;
    logic             drop;
    logic [OUT_W-1:0] head_nxt;

    assign full      = (level == LW'(FIFO_DEPTH));
    assign do_pop    = (level != '0) && out_ready;
    assign do_write  = s2_valid && (!full || do_pop);
    assign drop      = s2_valid && full && !do_pop;
    assign rptr_nxt  = do_pop ? rptr + AW'(1) : rptr;
    assign out_valid = (level != '0);
    assign fifo_level = level;

    always_comb begin
        level_nxt = level;
        if (do_write && !do_pop) begin
            level_nxt = level + LW'(1);
        end else if (!do_write && do_pop) begin
            level_nxt = level - LW'(1);
        end
    end

    // out_data is a register tracking the head; the slot written this edge
    // is forwarded so the head is correct even when it lands on the write slot.
    assign head_nxt = (do_write && (wptr == rptr_nxt)) ? s2_data : mem[rptr_nxt];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr] <= s2_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            if (do_write) begin
                wptr <= wptr + AW'(1);
            end
            rptr  <= rptr_nxt;
            level <= level_nxt;
            if (level_nxt != '0) begin
                out_data <= head_nxt;
            end
        end
    end

    // Sticky flags: a set event takes priority over a clear on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (s1_valid && conv_sat) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule
